// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the RV32 instruction encoder/loader: format select
// codes (shared with imm_select), error codes, loader state and range helper.
package instr_encoder_loader_pkg;

  localparam logic [2:0] FMT_R = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b011;
  localparam logic [2:0] FMT_I = 3'b111;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_FMT  = 2'b01;
  localparam logic [1:0] ERR_IMM  = 2'b10;
  localparam logic [1:0] ERR_FULL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } state_t;

  function automatic logic imm_in_range(input logic [31:0] imm,
                                        input int signed   lo,
                                        input int signed   hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/rv32_field_packer.sv
// Combinational packing of decoded RV32I fields into an instruction word,
// with format legality and immediate range/alignment flags.
module rv32_field_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        fmt_ok,
  output logic        imm_ok
);

  always_comb begin
    word   = '0;
    fmt_ok = 1'b1;
    imm_ok = 1'b1;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        word   = {imm[11:0], rs1, funct3, rd, opcode};
        imm_ok = imm_in_range(imm, -2048, 2047);
      end
      FMT_S: begin
        word   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        imm_ok = imm_in_range(imm, -2048, 2047);
      end
      FMT_B: begin
        word   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        imm_ok = imm_in_range(imm, -4096, 4094) && !imm[0];
      end
      default: fmt_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Serial RV32I instruction encoder/loader: accepts field bundles over
// valid/ready and writes packed words to consecutive instruction-memory words.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [2:0]            funct3,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST     = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  full;
  logic                  mem_we_q;
  logic [31:0]           word;
  logic                  fmt_ok;
  logic                  imm_ok;
  logic                  accept;

  rv32_field_packer u_packer (
    .fmt    (fmt),
    .opcode (opcode),
    .rd     (rd),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct7 (funct7),
    .imm    (imm),
    .word   (word),
    .fmt_ok (fmt_ok),
    .imm_ok (imm_ok)
  );

  assign accept = in_valid && in_ready;

  // A write registered on the previous edge is suppressed while reset is
  // high, so a reset arriving right after an accept never reaches memory.
  assign mem_we = mem_we_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr      <= '0;
      full      <= 1'b0;
      count     <= '0;
      in_ready  <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      mem_we_q <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            state    <= ST_RUN;
            addr     <= BASE;
            full     <= 1'b0;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            err      <= 1'b0;
            err_code <= ERR_NONE;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (!fmt_ok || !imm_ok) begin
              state    <= ST_ERROR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= fmt_ok ? ERR_IMM : ERR_FMT;
            end else begin
              mem_we_q  <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= word;
              addr      <= addr + ADDR_ONE;
              count     <= count + CNT_ONE;
              // in_ready tracks "RUN and not full" one cycle ahead
              if (addr == LAST) begin
                full     <= 1'b1;
                in_ready <= 1'b0;
              end
              if (in_last) begin
                state    <= ST_DONE;
                in_ready <= 1'b0;
                busy     <= 1'b0;
              end
            end
          end else if (in_valid && full) begin
            state    <= ST_ERROR;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_FULL;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: vector table, randomized
// sessions against a reference encoder/scoreboard, memory-full and reset cases.
module tb_instr_encoder_loader;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } bundle_t;

  typedef struct {
    string       name;
    bundle_t     b;
    logic [31:0] word;
    logic [1:0]  code;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;

  logic        a_in_ready, a_mem_we, a_busy, a_done, a_err;
  logic [7:0]  a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic [1:0]  a_err_code;
  logic [8:0]  a_count;

  logic        b_in_ready, b_mem_we, b_busy, b_done, b_err;
  logic [1:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [1:0]  b_err_code;
  logic [2:0]  b_count;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_last(in_last), .fmt(fmt), .opcode(opcode),
    .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .imm(imm), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .busy(a_busy), .done(a_done), .err(a_err),
    .err_code(a_err_code), .count(a_count)
  );

  instr_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_last(in_last), .fmt(fmt), .opcode(opcode),
    .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .imm(imm), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .busy(b_busy), .done(b_done), .err(b_err),
    .err_code(b_err_code), .count(b_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bundle_t mk(input logic [2:0] f, input logic [6:0] op,
                                 input logic [4:0] d, input logic [2:0] f3,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [6:0] f7, input logic [31:0] im);
    bundle_t b;
    b.fmt = f; b.opcode = op; b.rd = d; b.funct3 = f3;
    b.rs1 = s1; b.rs2 = s2; b.funct7 = f7; b.imm = im;
    return b;
  endfunction

  function automatic vec_t mkv(input string n, input bundle_t b,
                               input logic [31:0] w, input logic [1:0] c);
    vec_t v;
    v.name = n; v.b = b; v.word = w; v.code = c;
    return v;
  endfunction

  // Reference encoder: builds the word by shifting fields into place and
  // applies the range rules on the signed integer value.
  function automatic void ref_enc(input bundle_t b, output logic [31:0] w,
                                  output logic [1:0] code);
    int signed   v;
    logic [31:0] op, d, f3, s1, s2, f7, im;
    v = b.imm;
    im = b.imm;
    op = 32'(b.opcode); d = 32'(b.rd); f3 = 32'(b.funct3);
    s1 = 32'(b.rs1); s2 = 32'(b.rs2); f7 = 32'(b.funct7);
    code = 2'd0;
    w = 32'h0;
    case (b.fmt)
      3'b000: w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
      3'b111: begin
        if (v < -2048 || v > 2047) code = 2'd2;
        w = ((im & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
      end
      3'b001: begin
        if (v < -2048 || v > 2047) code = 2'd2;
        w = (((im >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
          | ((im & 32'h1F) << 7) | op;
      end
      3'b011: begin
        if (v < -4096 || v > 4094 || (v % 2) != 0) code = 2'd2;
        w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (s2 << 20)
          | (s1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8)
          | (((im >> 11) & 32'h1) << 7) | op;
      end
      default: code = 2'd1;
    endcase
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    int signed v;
    logic [2:0] legal [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
    b.fmt = legal[$urandom_range(0, 3)];
    b.opcode = 7'($urandom); b.rd = 5'($urandom); b.funct3 = 3'($urandom);
    b.rs1 = 5'($urandom); b.rs2 = 5'($urandom); b.funct7 = 7'($urandom);
    v = int'($urandom_range(0, 4095)) - 2048;
    if (b.fmt == 3'b011) v = v * 2;
    b.imm = (b.fmt == 3'b000) ? $urandom : v;
    return b;
  endfunction

  function automatic bundle_t bad_bundle();
    bundle_t b;
    logic [2:0] illegal [4] = '{3'b010, 3'b100, 3'b101, 3'b110};
    b = rand_bundle();
    case ($urandom_range(0, 2))
      0: b.fmt = illegal[$urandom_range(0, 3)];
      1: begin b.fmt = 3'b011; b.imm = 32'(2 * $urandom_range(0, 100) + 1); end
      default: begin b.fmt = 3'b111; b.imm = 32'(3000 + $urandom_range(0, 5000)); end
    endcase
    return b;
  endfunction

  task automatic drive(input bundle_t b);
    fmt = b.fmt; opcode = b.opcode; rd = b.rd; funct3 = b.funct3;
    rs1 = b.rs1; rs2 = b.rs2; funct7 = b.funct7; imm = b.imm;
  endtask

  task automatic begin_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Scoreboard: every write on the wide instance must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en && a_mem_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", a_mem_we, 1'b0);
      else chk("write", {a_mem_addr, a_mem_wdata}, exp_q.pop_front());
    end
  end

  vec_t vecs[15];

  initial begin
    bundle_t     b;
    logic [31:0] w;
    logic [1:0]  code;
    int          n, bad_at, acc, exp_addr;
    bit          gaps, v, errored;

    vecs[0]  = mkv("lw_neg4",   mk(3'b111, 7'b0000011, 5, 3'b010, 2, 0, 0, -4),        32'hFFC12283, 2'd0);
    vecs[1]  = mkv("sw_8",      mk(3'b001, 7'b0100011, 0, 3'b010, 2, 5, 0, 8),         32'h00512423, 2'd0);
    vecs[2]  = mkv("beq_neg8",  mk(3'b011, 7'b1100011, 0, 3'b000, 1, 2, 0, -8),        32'hFE208CE3, 2'd0);
    vecs[3]  = mkv("add",       mk(3'b000, 7'b0110011, 3, 3'b000, 1, 2, 0, 32'h12345), 32'h002081B3, 2'd0);
    vecs[4]  = mkv("sub",       mk(3'b000, 7'b0110011, 3, 3'b000, 1, 2, 7'h20, 0),     32'h402081B3, 2'd0);
    vecs[5]  = mkv("b_odd",     mk(3'b011, 7'b1100011, 0, 3'b000, 1, 2, 0, 3),         32'h0, 2'd2);
    vecs[6]  = mkv("fmt_bad",   mk(3'b010, 7'b0010011, 1, 3'b000, 0, 0, 0, 99999),     32'h0, 2'd1);
    vecs[7]  = mkv("fmt_bad2",  mk(3'b100, 7'b0010011, 1, 3'b000, 0, 0, 0, 0),         32'h0, 2'd1);
    vecs[8]  = mkv("addi_max",  mk(3'b111, 7'b0010011, 1, 3'b000, 0, 0, 0, 2047),      32'h7FF00093, 2'd0);
    vecs[9]  = mkv("addi_over", mk(3'b111, 7'b0010011, 1, 3'b000, 0, 0, 0, 2048),      32'h0, 2'd2);
    vecs[10] = mkv("sw_min",    mk(3'b001, 7'b0100011, 0, 3'b010, 0, 0, 0, -2048),     32'h80002023, 2'd0);
    vecs[11] = mkv("sw_under",  mk(3'b001, 7'b0100011, 0, 3'b010, 0, 0, 0, -2049),     32'h0, 2'd2);
    vecs[12] = mkv("b_max",     mk(3'b011, 7'b1100011, 0, 3'b000, 0, 0, 0, 4094),      32'h7E000FE3, 2'd0);
    vecs[13] = mkv("b_over",    mk(3'b011, 7'b1100011, 0, 3'b000, 0, 0, 0, 4096),      32'h0, 2'd2);
    vecs[14] = mkv("b_min",     mk(3'b011, 7'b1100011, 0, 3'b000, 0, 0, 0, -4096),     32'h80000063, 2'd0);

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_a", {a_in_ready, a_mem_we, a_mem_addr, a_mem_wdata, a_busy, a_done,
                    a_err, a_err_code, a_count}, '0);
    chk("reset_b", {b_in_ready, b_mem_we, b_mem_addr, b_mem_wdata, b_busy, b_done,
                    b_err, b_err_code, b_count}, '0);
    chk("idle_not_ready", a_in_ready, 1'b0);

    // Single-instruction sessions from the vector table.
    for (int i = 0; i < 15; i++) begin
      begin_session();
      chk({vecs[i].name, "/ready"}, a_in_ready, 1'b1);
      chk({vecs[i].name, "/err_clear"}, {a_err, a_err_code}, 3'b000);
      chk({vecs[i].name, "/count0"}, a_count, 0);
      drive(vecs[i].b);
      in_valid = 1'b1; in_last = 1'b1;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      if (vecs[i].code == 2'd0) begin
        chk({vecs[i].name, "/we"}, a_mem_we, 1'b1);
        chk({vecs[i].name, "/addr"}, a_mem_addr, 8'd0);
        chk({vecs[i].name, "/wdata"}, a_mem_wdata, vecs[i].word);
        chk({vecs[i].name, "/done_early"}, a_done, 1'b0);
        tick();
        chk({vecs[i].name, "/done"}, a_done, 1'b1);
        chk({vecs[i].name, "/we_once"}, a_mem_we, 1'b0);
        chk({vecs[i].name, "/count"}, a_count, 1);
        tick();
        chk({vecs[i].name, "/done_pulse"}, {a_done, a_busy}, 2'b00);
      end else begin
        chk({vecs[i].name, "/no_we"}, a_mem_we, 1'b0);
        chk({vecs[i].name, "/err"}, a_err, 1'b1);
        chk({vecs[i].name, "/err_code"}, a_err_code, vecs[i].code);
        chk({vecs[i].name, "/ready_low"}, a_in_ready, 1'b0);
        tick();
        chk({vecs[i].name, "/no_we_late"}, {a_mem_we, a_err}, 2'b01);
      end
    end

    // sw then beq back-to-back: consecutive addresses, write on every cycle.
    begin_session();
    drive(vecs[1].b); in_valid = 1'b1; in_last = 1'b0;
    tick();
    drive(vecs[2].b); in_last = 1'b1;
    chk("pair/w0", {a_mem_we, a_mem_addr, a_mem_wdata}, {1'b1, 8'd0, 32'h00512423});
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("pair/w1", {a_mem_we, a_mem_addr, a_mem_wdata}, {1'b1, 8'd1, 32'hFE208CE3});
    tick();
    chk("pair/done", {a_done, a_count}, {1'b1, 9'd2});

    // Randomized sessions against the reference encoder and write scoreboard.
    mon_en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      n = $urandom_range(3, 12);
      bad_at = (s >= 6) ? int'($urandom_range(0, n - 1)) : -1;
      gaps = (s != 0);
      acc = 0; exp_addr = 0; errored = 1'b0;
      begin_session();
      while (acc < n && !errored) begin
        v = !gaps || ($urandom_range(0, 3) != 0);
        b = (acc == bad_at) ? bad_bundle() : rand_bundle();
        ref_enc(b, w, code);
        drive(b);
        in_valid = v; in_last = (acc == n - 1);
        start = (acc == 1) && v;
        chk("rnd/ready", a_in_ready, 1'b1);
        if (v && code == 2'd0) exp_q.push_back({8'(exp_addr), w});
        tick();
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        if (v) begin
          if (code != 2'd0) begin
            errored = 1'b1;
            chk("rnd/err", {a_err, a_err_code}, {1'b1, code});
          end else begin
            exp_addr++;
            acc++;
            if (!gaps) chk("rnd/stream_we", a_mem_we, 1'b1);
          end
        end
      end
      if (!errored) begin
        tick();
        chk("rnd/done", {a_done, a_count}, {1'b1, 9'(n)});
      end
      tick(); tick();
      chk("rnd/drained", exp_q.size(), 0);
    end
    mon_en = 1'b0;

    // Memory full on the 4-word instance.
    begin_session();
    for (int i = 0; i < 4; i++) begin
      b = rand_bundle();
      ref_enc(b, w, code);
      drive(b); in_valid = 1'b1; in_last = 1'b0;
      tick();
      chk("full/write", {b_mem_we, b_mem_addr, b_mem_wdata}, {1'b1, 2'(i), w});
    end
    chk("full/count", b_count, 3'd4);
    chk("full/ready_low", {b_in_ready, b_err}, 2'b00);
    tick();
    in_valid = 1'b0;
    chk("full/err", {b_err, b_err_code}, {1'b1, 2'b11});
    chk("full/no_fifth_we", b_mem_we, 1'b0);

    // Reset right after an accept drops the pending write.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    begin_session();
    drive(vecs[0].b); in_valid = 1'b1; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst/drop_we", a_mem_we, 1'b0);
    tick();
    reset = 1'b0;
    chk("rst/outputs", {a_in_ready, a_mem_we, a_mem_addr, a_mem_wdata, a_busy, a_done,
                        a_err, a_err_code, a_count}, '0);
    tick();
    chk("rst/stay_idle", {a_mem_we, a_busy, a_in_ready}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
